spi_master_ctrl: RTL and testbench

System-clock SPI master (mode 0: CPOL=0, CPHA=0; MSB first) that generates `sclk`, `cs_n` and `mosi` for the team's `spi_slave`, and captures `miso` from it.

- Upstream logic supplies transmit words over a valid/ready handshake.
- A `tx_last` flag marks the final word of a chip-select frame.
- Each received word comes back as a one-cycle `rx_valid` pulse.
- All SPI pins are registered outputs derived from a single system clock, so the block sits directly upstream of `spi_slave` on a board or in a system bench.

---
 rtl/spi_master_ctrl_if.sv | 23 ++
 rtl/spi_master_ctrl.sv | 147 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// Upstream word interface of spi_master_ctrl: TX valid/ready handshake, RX pulse, status.
// The master modport is the upstream word source; the slave modport is the SPI controller.
interface spi_master_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_last;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             busy;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_valid, rx_data, busy
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Mode-0 (CPOL=0, CPHA=0) MSB-first SPI master clocked from the system clock.
// Chip select stays low across words until a word flagged tx_last has completed.
module spi_master_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_ctrl_if.slave bus,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StXfer, StNext, StHold, StGap} state_e;

  state_e           state_q, state_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic             last_q, last_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;

  logic tx_ready;
  logic accept;
  logic hwrap;

  assign tx_ready = (state_q == StIdle) || (state_q == StNext);
  assign accept   = bus.tx_valid && tx_ready;
  assign hwrap    = (hcnt_q == HMAX);

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    bcnt_d     = bcnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;

    unique case (state_q)
      StIdle, StNext: begin
        if (accept) begin
          state_d = StXfer;
          hcnt_d  = '0;
          bcnt_d  = '0;
          tx_sh_d = bus.tx_data;
          last_d  = bus.tx_last;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = bus.tx_data[WIDTH-1];
        end
      end
      StXfer: begin
        if (hwrap) begin
          hcnt_d = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising sclk edge: capture the bit the slave drove on the previous fall.
            rx_sh_d = {rx_sh_q[WIDTH-2:0], miso};
          end else if (bcnt_q == BMAX) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            state_d    = last_q ? StHold : StNext;
          end else begin
            tx_sh_d = tx_sh_q << 1;
            mosi_d  = tx_sh_q[WIDTH-2];
            bcnt_d  = bcnt_q + BW'(1);
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      StHold: begin
        if (hwrap) begin
          hcnt_d  = '0;
          state_d = StGap;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      StGap: begin
        if (hwrap) begin
          hcnt_d  = '0;
          state_d = StIdle;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hcnt_q     <= '0;
      bcnt_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      bcnt_q     <= bcnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      last_q     <= last_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign sclk         = sclk_q;
  assign cs_n         = cs_n_q;
  assign mosi         = mosi_q;
  assign bus.tx_ready = tx_ready;
  assign bus.busy     = (state_q != StIdle);
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: three instances (CLK_DIV 2, 1, 5) share one behavioural
// mode-0 slave through a select mux; expected words are queued and matched on output.
module tb_spi_master_ctrl;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int cur_div = 2;

  logic         tv = 1'b0;
  logic [W-1:0] td = '0;
  logic         tl = 1'b0;
  logic         miso = 1'b0;

  spi_master_ctrl_if #(.WIDTH(W)) bus0 ();
  spi_master_ctrl_if #(.WIDTH(W)) bus1 ();
  spi_master_ctrl_if #(.WIDTH(W)) bus2 ();

  assign bus0.tx_valid = tv && (sel == 0);
  assign bus1.tx_valid = tv && (sel == 1);
  assign bus2.tx_valid = tv && (sel == 2);
  assign bus0.tx_data  = td;
  assign bus1.tx_data  = td;
  assign bus2.tx_data  = td;
  assign bus0.tx_last  = tl;
  assign bus1.tx_last  = tl;
  assign bus2.tx_last  = tl;

  logic sclk0, cs_n0, mosi0, sclk1, cs_n1, mosi1, sclk2, cs_n2, mosi2;

  spi_master_ctrl #(.WIDTH(W), .CLK_DIV(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso)
  );
  spi_master_ctrl #(.WIDTH(W), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso)
  );
  spi_master_ctrl #(.WIDTH(W), .CLK_DIV(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2), .miso(miso)
  );

  logic m_ready, m_rxv, m_busy, m_sclk, m_cs_n, m_mosi;
  logic [W-1:0] m_rxd;

  always_comb begin
    m_ready = bus0.tx_ready; m_rxv = bus0.rx_valid; m_rxd = bus0.rx_data; m_busy = bus0.busy;
    m_sclk  = sclk0; m_cs_n = cs_n0; m_mosi = mosi0;
    if (sel == 1) begin
      m_ready = bus1.tx_ready; m_rxv = bus1.rx_valid; m_rxd = bus1.rx_data; m_busy = bus1.busy;
      m_sclk  = sclk1; m_cs_n = cs_n1; m_mosi = mosi1;
    end else if (sel == 2) begin
      m_ready = bus2.tx_ready; m_rxv = bus2.rx_valid; m_rxd = bus2.rx_data; m_busy = bus2.busy;
      m_sclk  = sclk2; m_cs_n = cs_n2; m_mosi = mosi2;
    end
  end

  // Scoreboard queues: expectations pushed with stimulus, observations pushed by monitors.
  logic [W-1:0] resp_q[$];
  logic [W-1:0] exp_rx_q[$];
  logic [W-1:0] exp_mosi_q[$];
  logic [W-1:0] cap_q[$];
  logic [W-1:0] rx_dat_q[$];
  int           rx_cyc_q[$];
  int           rise_q[$];
  int           hi_q[$];
  int           rise_cnt = 0;
  int           cs_rise_cnt = 0;

  // Behavioural mode-0 slave: samples mosi on sclk rise, shifts miso on sclk fall.
  logic         s_sclk = 1'b0;
  logic         s_cs = 1'b1;
  logic [W-1:0] slv_sh = '0;
  logic [W-1:0] slv_rx = '0;
  int           slv_cnt = 0;
  always @(m_sclk or m_cs_n) begin
    if (s_cs && !m_cs_n) begin
      slv_cnt = 0;
      slv_sh  = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
      miso    = slv_sh[W-1];
    end else if (!s_sclk && m_sclk && !m_cs_n) begin
      slv_rx  = {slv_rx[W-2:0], m_mosi};
      slv_cnt = slv_cnt + 1;
      if (slv_cnt == W) begin
        cap_q.push_back(slv_rx);
        slv_cnt = 0;
      end
    end else if (s_sclk && !m_sclk) begin
      if (slv_cnt == 0) slv_sh = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
      else              slv_sh = slv_sh << 1;
      miso = slv_sh[W-1];
    end
    s_sclk = m_sclk;
    s_cs   = m_cs_n;
  end

  logic mon_sclk = 1'b0;
  logic mon_cs = 1'b1;
  int   hi_len = 0;
  always @(negedge clk) begin
    if (m_rxv) begin
      rx_dat_q.push_back(m_rxd);
      rx_cyc_q.push_back(cyc);
    end
    if (m_sclk && !mon_sclk) begin
      rise_cnt = rise_cnt + 1;
      rise_q.push_back(cyc);
      hi_len = 1;
    end else if (m_sclk) begin
      hi_len = hi_len + 1;
    end
    if (!m_sclk && mon_sclk && !m_cs_n) hi_q.push_back(hi_len);
    if (m_cs_n && !mon_cs) cs_rise_cnt = cs_rise_cnt + 1;
    mon_sclk = m_sclk;
    mon_cs   = m_cs_n;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last, output int acc);
    int n = 0;
    tv = 1'b1; td = d; tl = last;
    while (!m_ready && n < 300) begin tick(); n++; end
    if (!m_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout word %h tx_ready stayed 0 for %0d cycles", d, n);
      tv = 1'b0; acc = 0;
      return;
    end
    tick();
    acc = cyc;
    tv  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(m_ready && !m_busy) && n < 1000) begin tick(); n++; end
    if (!(m_ready && !m_busy)) begin
      checks++; errors++;
      $display("FAIL idle_timeout busy=%b tx_ready=%b after %0d cycles", m_busy, m_ready, n);
    end
  endtask

  task automatic test_reset();
    tv = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (m_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", m_cs_n); end
    checks++; if (m_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", m_sclk); end
    checks++; if (m_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", m_mosi); end
    checks++; if (m_rxv !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", m_rxv); end
    checks++; if (m_rxd !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", m_rxd); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", m_busy); end
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", m_ready); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_word();
    int acc, r0, n, bad;
    logic [W-1:0] e;
    resp_q.push_back(8'hA5); exp_rx_q.push_back(8'hA5); exp_mosi_q.push_back(8'h3C);
    r0 = rise_cnt; hi_q.delete();
    send(8'h3C, 1'b1, acc);
    n = 0;
    while (rx_dat_q.size() == 0 && n < 200) begin tick(); n++; end
    checks++;
    if (rx_dat_q.size() == 0) begin
      errors++; $display("FAIL single_rx_valid got none want one pulse");
    end else begin
      e = exp_rx_q.pop_front();
      if (rx_dat_q[0] !== e) begin
        errors++; $display("FAIL single_rx_data got %h want %h", rx_dat_q[0], e);
      end
      checks++;
      if (rx_cyc_q[0] - acc != 32) begin
        errors++; $display("FAIL single_latency got %0d want 32", rx_cyc_q[0] - acc);
      end
      void'(rx_dat_q.pop_front()); void'(rx_cyc_q.pop_front());
      n = 0;
      while (m_cs_n !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (n != 2) begin errors++; $display("FAIL single_cs_rise got %0d want 2", n); end
      n = 0;
      while (m_ready !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (n != 2) begin errors++; $display("FAIL single_ready got %0d want 2", n); end
    end
    wait_idle();
    e = exp_mosi_q.pop_front();
    checks++;
    if (cap_q.size() != 1 || cap_q[0] !== e) begin
      errors++; $display("FAIL single_mosi got %0d words first %h want %h", cap_q.size(),
                         (cap_q.size() > 0) ? cap_q[0] : 8'hxx, e);
    end
    cap_q.delete();
    checks++; if (rise_cnt - r0 != 8) begin
      errors++; $display("FAIL single_rises got %0d want 8", rise_cnt - r0);
    end
    bad = 0;
    foreach (hi_q[i]) if (hi_q[i] != cur_div) bad++;
    checks++; if (bad != 0 || hi_q.size() != 8) begin
      errors++; $display("FAIL single_sclk_high got %0d bad of %0d want 0 of 8", bad, hi_q.size());
    end
  endtask

  task automatic test_frame();
    logic [W-1:0] words[4] = '{8'h3C, 8'h80, 8'h36, 8'h1B};
    logic [W-1:0] resps[4] = '{8'hC3, 8'h01, 8'h7E, 8'hD4};
    int acc[4];
    int r0, c0, bad;
    logic [W-1:0] e;
    for (int i = 0; i < 4; i++) begin
      resp_q.push_back(resps[i]); exp_rx_q.push_back(resps[i]); exp_mosi_q.push_back(words[i]);
    end
    r0 = rise_cnt; c0 = cs_rise_cnt; rise_q.delete();
    for (int i = 0; i < 4; i++) send(words[i], (i == 3), acc[i]);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_dat_q.size() == 0) begin
        errors++; $display("FAIL frame_rx_missing word %0d got none want %h", i, resps[i]);
      end else begin
        e = exp_rx_q.pop_front();
        if (rx_dat_q[0] !== e) begin
          errors++; $display("FAIL frame_rx_data word %0d got %h want %h", i, rx_dat_q[0], e);
        end
        checks++;
        if (rx_cyc_q[0] - acc[i] != 32) begin
          errors++; $display("FAIL frame_latency word %0d got %0d want 32", i, rx_cyc_q[0] - acc[i]);
        end
        void'(rx_dat_q.pop_front()); void'(rx_cyc_q.pop_front());
      end
      checks++;
      e = exp_mosi_q.pop_front();
      if (cap_q.size() == 0 || cap_q[0] !== e) begin
        errors++; $display("FAIL frame_mosi word %0d got %h want %h", i,
                           (cap_q.size() > 0) ? cap_q[0] : 8'hxx, e);
      end
      if (cap_q.size() > 0) void'(cap_q.pop_front());
    end
    checks++; if (cs_rise_cnt - c0 != 1) begin
      errors++; $display("FAIL frame_cs_rises got %0d want 1", cs_rise_cnt - c0);
    end
    checks++; if (rise_cnt - r0 != 32) begin
      errors++; $display("FAIL frame_rises got %0d want 32", rise_cnt - r0);
    end
    bad = 0;
    for (int i = 1; i < rise_q.size(); i++)
      if ((i % 8) != 0 && rise_q[i] - rise_q[i-1] != 2 * cur_div) bad++;
    checks++; if (bad != 0) begin
      errors++; $display("FAIL frame_sclk_period got %0d irregular want 0", bad);
    end
  endtask

  task automatic test_backpressure();
    int acc_a, acc_b, n;
    logic [W-1:0] e;
    resp_q.push_back(8'h9D); resp_q.push_back(8'h42);
    exp_rx_q.push_back(8'h9D); exp_rx_q.push_back(8'h42);
    exp_mosi_q.push_back(8'h96); exp_mosi_q.push_back(8'h69);
    send(8'h96, 1'b0, acc_a);
    n = 0;
    while (rx_dat_q.size() == 0 && n < 200) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (m_sclk !== 1'b0 || m_cs_n !== 1'b0 || m_busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold cycle %0d got sclk=%b cs_n=%b busy=%b want 0 0 1",
                           i, m_sclk, m_cs_n, m_busy);
      end
      tick();
    end
    rise_q.delete();
    send(8'h69, 1'b1, acc_b);
    wait_idle();
    checks++;
    if (rise_q.size() == 0 || rise_q[0] - acc_b != cur_div) begin
      errors++; $display("FAIL bp_first_half got %0d want %0d",
                         (rise_q.size() > 0) ? rise_q[0] - acc_b : -1, cur_div);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      e = exp_rx_q.pop_front();
      if (rx_dat_q.size() == 0 || rx_dat_q[0] !== e ||
          rx_cyc_q[0] - ((i == 0) ? acc_a : acc_b) != 32) begin
        errors++; $display("FAIL bp_rx word %0d got %h want %h", i,
                           (rx_dat_q.size() > 0) ? rx_dat_q[0] : 8'hxx, e);
      end
      if (rx_dat_q.size() > 0) begin void'(rx_dat_q.pop_front()); void'(rx_cyc_q.pop_front()); end
      checks++;
      e = exp_mosi_q.pop_front();
      if (cap_q.size() == 0 || cap_q[0] !== e) begin
        errors++; $display("FAIL bp_mosi word %0d got %h want %h", i,
                           (cap_q.size() > 0) ? cap_q[0] : 8'hxx, e);
      end
      if (cap_q.size() > 0) void'(cap_q.pop_front());
    end
  endtask

  task automatic test_reset_mid();
    int acc, r0, n;
    logic [W-1:0] e;
    resp_q.push_back(8'hFF);
    r0 = rise_cnt;
    send(8'hF0, 1'b1, acc);
    n = 0;
    while (rise_cnt - r0 < 3 && n < 100) begin tick(); n++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (m_cs_n !== 1'b1 || m_sclk !== 1'b0 || m_mosi !== 1'b0 || m_busy !== 1'b0) begin
      errors++; $display("FAIL abort_async got cs_n=%b sclk=%b mosi=%b busy=%b want 1 0 0 0",
                         m_cs_n, m_sclk, m_mosi, m_busy);
    end
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    checks++; if (rx_dat_q.size() != 0 || cap_q.size() != 0) begin
      errors++; $display("FAIL abort_no_rx got %0d rx %0d captures want 0 0",
                         rx_dat_q.size(), cap_q.size());
    end
    rx_dat_q.delete(); rx_cyc_q.delete(); cap_q.delete(); resp_q.delete();
    resp_q.push_back(8'hAA); exp_rx_q.push_back(8'hAA); exp_mosi_q.push_back(8'h55);
    send(8'h55, 1'b1, acc);
    wait_idle();
    checks++;
    e = exp_rx_q.pop_front();
    if (rx_dat_q.size() != 1 || rx_dat_q[0] !== e || rx_cyc_q[0] - acc != 32) begin
      errors++; $display("FAIL abort_after_rx got %0d words first %h want %h", rx_dat_q.size(),
                         (rx_dat_q.size() > 0) ? rx_dat_q[0] : 8'hxx, e);
    end
    rx_dat_q.delete(); rx_cyc_q.delete();
    checks++;
    e = exp_mosi_q.pop_front();
    if (cap_q.size() != 1 || cap_q[0] !== e) begin
      errors++; $display("FAIL abort_after_mosi got %h want %h",
                         (cap_q.size() > 0) ? cap_q[0] : 8'hxx, e);
    end
    cap_q.delete();
  endtask

  task automatic test_clk_div();
    int divs[2] = '{1, 5};
    logic [W-1:0] resps[2] = '{8'h5A, 8'h81};
    int acc, bad;
    logic [W-1:0] e;
    for (int k = 0; k < 2; k++) begin
      sel = k + 1; cur_div = divs[k];
      tick();
      resp_q.push_back(resps[k]); exp_rx_q.push_back(resps[k]); exp_mosi_q.push_back(8'hC3);
      rise_q.delete();
      send(8'hC3, 1'b1, acc);
      wait_idle();
      checks++;
      e = exp_rx_q.pop_front();
      if (rx_dat_q.size() != 1 || rx_dat_q[0] !== e) begin
        errors++; $display("FAIL div%0d_rx_data got %h want %h", cur_div,
                           (rx_dat_q.size() > 0) ? rx_dat_q[0] : 8'hxx, e);
      end
      checks++;
      if (rx_cyc_q.size() == 0 || rx_cyc_q[0] - acc != 16 * cur_div) begin
        errors++; $display("FAIL div%0d_latency got %0d want %0d", cur_div,
                           (rx_cyc_q.size() > 0) ? rx_cyc_q[0] - acc : -1, 16 * cur_div);
      end
      rx_dat_q.delete(); rx_cyc_q.delete();
      bad = 0;
      for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != 2 * cur_div) bad++;
      checks++; if (bad != 0 || rise_q.size() != 8) begin
        errors++; $display("FAIL div%0d_period got %0d irregular of %0d rises want 0 of 8",
                           cur_div, bad, rise_q.size());
      end
      checks++;
      e = exp_mosi_q.pop_front();
      if (cap_q.size() != 1 || cap_q[0] !== e) begin
        errors++; $display("FAIL div%0d_mosi got %h want %h", cur_div,
                           (cap_q.size() > 0) ? cap_q[0] : 8'hxx, e);
      end
      cap_q.delete();
    end
    sel = 0; cur_div = 2;
    tick();
  endtask

  task automatic test_ignored_handshake();
    int acc, n, r0;
    logic [W-1:0] e;
    resp_q.push_back(8'h3C); exp_rx_q.push_back(8'h3C); exp_mosi_q.push_back(8'hE7);
    r0 = rise_cnt;
    send(8'hE7, 1'b1, acc);
    n = 0;
    // Toggle a competing word on tx_valid through XFER, HOLD and GAP.
    while (!m_ready && n < 200) begin
      tv = n[0]; td = 8'h00; tl = 1'b0;
      tick(); n++;
    end
    tv = 1'b0;
    repeat (3) tick();
    checks++; if (m_busy !== 1'b0) begin
      errors++; $display("FAIL ignored_busy got %b want 0", m_busy);
    end
    checks++;
    e = exp_rx_q.pop_front();
    if (rx_dat_q.size() != 1 || rx_dat_q[0] !== e) begin
      errors++; $display("FAIL ignored_rx got %0d words first %h want %h", rx_dat_q.size(),
                         (rx_dat_q.size() > 0) ? rx_dat_q[0] : 8'hxx, e);
    end
    rx_dat_q.delete(); rx_cyc_q.delete();
    checks++;
    e = exp_mosi_q.pop_front();
    if (cap_q.size() != 1 || cap_q[0] !== e || rise_cnt - r0 != 8) begin
      errors++; $display("FAIL ignored_mosi got %h rises %0d want %h rises 8",
                         (cap_q.size() > 0) ? cap_q[0] : 8'hxx, rise_cnt - r0, e);
    end
    cap_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_frame();
    test_backpressure();
    test_reset_mid();
    test_clk_div();
    test_ignored_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
